// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word adder sequencer: controller state
// encoding and the default slice geometry.
package adder_pkg;

  // Controller states; the encodings are fixed so waveforms stay readable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default geometry: a 4-bit slice used four times gives a 16-bit add.
  localparam int DEF_SLICE_W    = 4;
  localparam int DEF_NUM_SLICES = 4;

endpackage : adder_pkg

// File: rtl/add_slice.sv
// Combinational SLICE_W-bit ripple-carry adder slice. Besides the carry-out
// it exposes the carry into its top bit so the caller can form the signed
// overflow flag when this slice holds the operand MSBs.
module add_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out,
  output logic               msb_carry_in
);

  // Ripple the carry bit by bit from the LSB upwards.
  always_comb begin
    logic c;
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (which would infer a latch).
    sum          = '0;
    msb_carry_in = 1'b0;
    c            = c_in;
    for (int i = 0; i < SLICE_W; i++) begin
      // The last iteration leaves the carry into the top bit here.
      msb_carry_in = c;
      sum[i]       = a[i] ^ b[i] ^ c;
      c            = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    c_out = c;
  end

endmodule : add_slice

// File: rtl/multiword_add_ctrl.sv
// Multi-word adder sequencer: performs a SLICE_W*NUM_SLICES-bit addition by
// feeding one shared SLICE_W-bit add_slice, least-significant slice first,
// with the inter-slice carry held in a register. Operands come in and the
// result goes out over valid/ready handshakes.
//
// Build option: define MULTIWORD_ADD_SUB_EN to add a 'sub' input. With sub=1
// the operation is a - b: b is inverted when latched, c_in acts as borrow-in
// and c_out reports borrow-out. Without the macro the block only adds.
module multiword_add_ctrl
  import adder_pkg::*;
#(
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] a,
  input  logic [SLICE_W*NUM_SLICES-1:0] b,
  input  logic                          c_in,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                          sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] sum,
  output logic                          c_out,
  output logic                          ovf
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;        // operand A shift register
  logic [W-1:0]     b_q, b_d;        // operand B shift register (pre-inverted when subtracting)
  logic [W-1:0]     acc_q, acc_d;    // partial result, filled from the top
  logic [W-1:0]     sum_q, sum_d;    // last complete result, presented on sum
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               sub_w;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;
  logic               s_msb_cin;
  logic [W-1:0]       acc_shift;

`ifdef MULTIWORD_ADD_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  add_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a            (a_q[SLICE_W-1:0]),
    .b            (b_q[SLICE_W-1:0]),
    .c_in         (carry_q),
    .sum          (s_sum),
    .c_out        (s_cout),
    .msb_carry_in (s_msb_cin)
  );

  // New slice result enters at the top; after NUM_SLICES shifts the
  // first slice has reached the LSB position.
  assign acc_shift = (acc_q >> SLICE_W) | (W'(s_sum) << (W - SLICE_W));

  // Next-state and handshake logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    sub_d     = sub_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_w ? ~b : b;
          carry_d = c_in ^ sub_w;
          sub_d   = sub_w;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        acc_d   = acc_shift;
        carry_d = s_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Publish the finished result in one step so no partial
          // value ever appears on the outputs.
          sum_d   = acc_shift;
          c_out_d = s_cout ^ sub_q;
          ovf_d   = s_cout ^ s_msb_cin;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all of these are plain flops rather than a memory, so every one is cleared by reset; an abandoned operation leaves nothing behind.
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule : multiword_add_ctrl

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
Sequencer that performs a wide (SLICE_W*NUM_SLICES-bit) addition by time-multiplexing one SLICE_W-bit ripple-carry adder slice, least-significant slice first.
- Carry is held in a register between cycles.
- Operands are accepted and results returned over valid/ready handshakes.
- Sits between a requester and the shared narrow adder datapath. Trades latency for area when full-width adders are too large.

Parameters:
SLICE_W, 4, width of the shared adder slice in bits (>=1)
NUM_SLICES, 4, number of slices per operation (>=1); total operand width W = SLICE_W*NUM_SLICES

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
c_in  input  1  carry-in (borrow-in when subtracting, see Optional Feature)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result
c_out  output  1  carry-out of MSB slice
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0; all internal registers cleared. Reset mid-operation discards the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch a, b into operand shift registers; carry_reg<=c_in; slice_cnt<=0; go RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle the slice adds a_reg[SLICE_W-1:0] + b_reg[SLICE_W-1:0] + carry_reg.
    - Slice result is shifted into the top of sum_reg (shift right by SLICE_W).
    - a_reg and b_reg shift right by SLICE_W.
    - carry_reg<=slice carry-out; slice_cnt++.
    - On the cycle slice_cnt==NUM_SLICES-1: also capture ovf from MSB-bit carries; go DONE.
  - DONE: out_valid=1, sum/c_out/ovf stable. in_ready=0 (no accept in same cycle as result handoff). On out_ready: go IDLE, out_valid<=0. sum/c_out/ovf keep their last values until the next result.
- Latency: accept at edge k, out_valid=1 after edge k+NUM_SLICES. Throughput is one op per NUM_SLICES+2 cycles with out_ready held high.
- Arithmetic is modulo 2^W; c_out is the true carry of the W-bit sum.
- slice_cnt width = max(1, clog2(NUM_SLICES)). NUM_SLICES=1 gives a single RUN cycle.
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- in_valid while not IDLE is ignored; the requester must hold it until in_ready.
- in_valid and a/b/c_in changes outside the accept cycle do not affect an operation in flight.

Optional Feature:
Macro MULTIWORD_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled at accept.
  - When sub=1: b is inverted at latch; effective carry-in = ~c_in (c_in acts as borrow-in); reported c_out = ~final carry (borrow-out); ovf computed on the inverted-b addition.
  - When sub=0: identical to plain add.
- Undefined: no sub port; add only.

Decomposition:
- Shared package adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default SLICE_W/NUM_SLICES constants
- One natural sub-module: add_slice. Combinational SLICE_W-bit ripple-carry adder with a, b, c_in → sum, c_out, plus msb_carry_in for ovf. It is instantiated once; the controller owns all sequential state.

Test Plan:
1. Reset, then a=0x1234, b=0x4321, c_in=0 → out_valid exactly 4 cycles after accept, sum=0x5555, c_out=0, ovf=0.
2. a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
3. a=0x0000, b=0xFFFF, c_in=1 → sum=0x0000, c_out=1 (carry-in ripples through all 4 slices).
4. Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/c_out/ovf/out_valid stable, in_ready=0; in_valid pulses during that time are ignored. out_ready=1 → IDLE next cycle, in_ready=1.
5. Assert reset after 2 RUN cycles of a=0xABCD+0x1111 → outputs immediately 0, in_ready=1. After release, a new op 0x0001+0x0001 → sum=0x0002.
6. With MULTIWORD_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007, c_in=0 → sum=0xFFFE, c_out=1 (borrow), ovf=0. sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=0, ovf=1.
